// File: rtl/fp_mant_divider.sv
// ============================================================================
// Module   : fp_mant_divider
// Purpose  : Iterative restoring divider for MANT_W-bit FP mantissas (hidden bit
//            included); quotient = floor(dividend * 2^(MANT_W-1) / divisor).
//            Optional macro FP_DIV_RADIX4_EN retires two quotient bits per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mant_divider #(
    parameter int MANT_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] dividend,
    input  logic [MANT_W-1:0] divisor,
    output logic [MANT_W-1:0] quotient,
    output logic              sticky,
    output logic              div_by_zero,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (MANT_W > 1) ? $clog2(MANT_W) : 1;
`ifdef FP_DIV_RADIX4_EN
    // MANT_W must be even so that the count lands exactly on 1 for the last pair
    localparam logic [CNT_W-1:0] C_STEP = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] C_STEP = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(0);
`endif
    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(MANT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MANT_W:0]     rem_q,    rem_d;
    logic [MANT_W-1:0]   dvs_q,    dvs_d;
    logic [MANT_W-1:0]   quo_q,    quo_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                sticky_q, sticky_d;
    logic                dbz_q,    dbz_d;

    logic [MANT_W:0]     w_dvs_ext;
    logic                w_ge1;
    logic [MANT_W:0]     w_sub1;
    logic [MANT_W:0]     w_rem1;
    logic [MANT_W:0]     w_sub_last;
    logic [MANT_W:0]     w_rem_last;

    assign w_dvs_ext = {1'b0, dvs_q};

    // First restoring step: compare, conditionally subtract, shift left
    assign w_ge1  = (rem_q >= w_dvs_ext);
    assign w_sub1 = w_ge1 ? (rem_q - w_dvs_ext) : rem_q;
    assign w_rem1 = {w_sub1[MANT_W-1:0], 1'b0};

`ifdef FP_DIV_RADIX4_EN
    logic                w_ge2;
    logic [MANT_W:0]     w_sub2;
    logic [CNT_W-1:0]    w_cnt_lo;

    // Second step cascaded on the first one's shifted remainder
    assign w_ge2      = (w_rem1 >= w_dvs_ext);
    assign w_sub2     = w_ge2 ? (w_rem1 - w_dvs_ext) : w_rem1;
    assign w_sub_last = w_sub2;
    assign w_rem_last = {w_sub2[MANT_W-1:0], 1'b0};
    assign w_cnt_lo   = cnt_q - CNT_W'(1);
`else
    assign w_sub_last = w_sub1;
    assign w_rem_last = w_rem1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvs_d    = divisor;
                    rem_d    = {1'b0, dividend};
                    sticky_d = 1'b0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        dbz_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        quo_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = C_CNT_INIT;
                        state_d = S_RUN;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                quo_d[cnt_q] = w_ge1;
`ifdef FP_DIV_RADIX4_EN
                quo_d[w_cnt_lo] = w_ge2;
`endif
                rem_d = w_rem_last;
                cnt_d = cnt_q - C_STEP;
                if (cnt_q == C_LAST) begin
                    sticky_d = |w_sub_last;
                    state_d  = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign quotient    = quo_q;
    assign sticky      = sticky_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fp_mant_divider.sv
// ============================================================================
// Module   : tb_fp_mant_divider
// Purpose  : Directed self-checking bench for fp_mant_divider (radix-2 default,
//            radix-4 timing when FP_DIV_RADIX4_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mant_divider;

    localparam int MANT_W = 24;
`ifdef FP_DIV_RADIX4_EN
    localparam int LAT = MANT_W / 2;
`else
    localparam int LAT = MANT_W;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [MANT_W-1:0] dividend;
    logic [MANT_W-1:0] divisor;
    logic [MANT_W-1:0] quotient;
    logic              sticky;
    logic              div_by_zero;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    fp_mant_divider #(.MANT_W(MANT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .sticky      (sticky),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start is sampled by the edge inside this task (edge 0 of the operation)
    task automatic apply_start(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 24'h3C3C3C;
        divisor  = 24'h0F0F0F;
    endtask

    // Returns the edge index at which done was first seen, -1 on timeout
    task automatic wait_done(input int first_edge, output int edges, output logic busy_ok);
        edges   = -1;
        busy_ok = 1'b1;
        for (int k = first_edge; k <= LAT + 8; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            if (done === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (quotient !== 24'h0) begin failures++; $display("FAIL reset_quotient: got %h want %h", quotient, 24'h0); end
        checks++; if (sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky: got %b want 0", sticky); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_divide();
        logic [MANT_W-1:0] va [7];
        logic [MANT_W-1:0] vb [7];
        logic [MANT_W-1:0] vq [7];
        logic              vs [7];
        int                lat;
        logic              bok;
        va[0] = 24'h800000; vb[0] = 24'h800000; vq[0] = 24'h800000; vs[0] = 1'b0;
        va[1] = 24'hC00000; vb[1] = 24'h800000; vq[1] = 24'hC00000; vs[1] = 1'b0;
        va[2] = 24'h800000; vb[2] = 24'hC00000; vq[2] = 24'h555555; vs[2] = 1'b1;
        va[3] = 24'hFFFFFF; vb[3] = 24'h800000; vq[3] = 24'hFFFFFF; vs[3] = 1'b0;
        va[4] = 24'h800000; vb[4] = 24'hFFFFFF; vq[4] = 24'h400000; vs[4] = 1'b1;
        va[5] = 24'hA00000; vb[5] = 24'hC00000; vq[5] = 24'h6AAAAA; vs[5] = 1'b1;
        va[6] = 24'h000003; vb[6] = 24'h800000; vq[6] = 24'h000003; vs[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            apply_start(va[i], vb[i]);
            wait_done(1, lat, bok);
            checks++; if (lat != LAT) begin failures++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, LAT); end
            checks++; if (bok !== 1'b1) begin failures++; $display("FAIL div%0d_busy: busy dropped before done, got %b want 1", i, bok); end
            checks++; if (quotient !== vq[i]) begin failures++; $display("FAIL div%0d_quotient: got %h want %h", i, quotient, vq[i]); end
            checks++; if (sticky !== vs[i]) begin failures++; $display("FAIL div%0d_sticky: got %b want %b", i, sticky, vs[i]); end
            checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL div%0d_dbz: got %b want 0", i, div_by_zero); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div%0d_busy_at_done: got %b want 0", i, busy); end
            tick();
            tick();
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL div%0d_done_pulse: got %b want 0", i, done); end
            checks++; if (quotient !== vq[i]) begin failures++; $display("FAIL div%0d_hold: got %h want %h", i, quotient, vq[i]); end
        end
    endtask

    task automatic test_div_by_zero();
        apply_start(24'hA00000, 24'h000000);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL dbz_done: got %b want 1", done); end
        checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
        checks++; if (quotient !== 24'hFFFFFF) begin failures++; $display("FAIL dbz_quotient: got %h want %h", quotient, 24'hFFFFFF); end
        checks++; if (sticky !== 1'b0) begin failures++; $display("FAIL dbz_sticky: got %b want 0", sticky); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dbz_busy: got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL dbz_done_clear: got %b want 0", done); end
        checks++; if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_hold: got %b want 1", div_by_zero); end
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic bok;
        apply_start(24'h800000, 24'h800000);
        for (int k = 1; k <= 9; k++) tick();
        // Request presented at edge 10 while busy must be ignored
        dividend = 24'hFFFFFF;
        divisor  = 24'h800000;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(11, lat, bok);
        checks++; if (lat != LAT) begin failures++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
        checks++; if (quotient !== 24'h800000) begin failures++; $display("FAIL ignore_quotient: got %h want %h", quotient, 24'h800000); end
        checks++; if (sticky !== 1'b0) begin failures++; $display("FAIL ignore_sticky: got %b want 0", sticky); end
        // Start during the DONE cycle is accepted
        apply_start(24'h800000, 24'hC00000);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_low: got %b want 0", done); end
        wait_done(1, lat, bok);
        checks++; if (lat != LAT) begin failures++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
        checks++; if (quotient !== 24'h555555) begin failures++; $display("FAIL b2b_quotient: got %h want %h", quotient, 24'h555555); end
        checks++; if (sticky !== 1'b1) begin failures++; $display("FAIL b2b_sticky: got %b want 1", sticky); end
        tick();
    endtask

    task automatic test_reset_abort();
        int   lat;
        logic bok;
        logic saw_done;
        apply_start(24'hC00000, 24'h800000);
        for (int k = 1; k <= 11; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (quotient !== 24'h0) begin failures++; $display("FAIL abort_quotient: got %h want %h", quotient, 24'h0); end
        checks++; if (sticky !== 1'b0) begin failures++; $display("FAIL abort_sticky: got %b want 0", sticky); end
        checks++; if (div_by_zero !== 1'b0) begin failures++; $display("FAIL abort_dbz: got %b want 0", div_by_zero); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b want 0", done); end
        saw_done = 1'b0;
        for (int k = 0; k < LAT + 4; k++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done: got %b want 0", saw_done); end
        apply_start(24'hC00000, 24'h800000);
        wait_done(1, lat, bok);
        checks++; if (lat != LAT) begin failures++; $display("FAIL fresh_latency: got %0d want %0d", lat, LAT); end
        checks++; if (quotient !== 24'hC00000) begin failures++; $display("FAIL fresh_quotient: got %h want %h", quotient, 24'hC00000); end
        checks++; if (sticky !== 1'b0) begin failures++; $display("FAIL fresh_sticky: got %b want 0", sticky); end
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_divide();
        test_div_by_zero();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
